logic_probe_counter: RTL and testbench

LOGIC_PROBE_COUNTER -- requirements
Module: logic_probe_counter

---
 rtl/logic_probe_pkg.sv | 30 +++
 rtl/probe_sync.sv | 24 ++
 rtl/logic_probe_counter.sv | 149 ++++++++++++++
 tb/tb_logic_probe_counter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_probe_pkg.sv
// Shared encodings for the logic probe counter: sample classes, FSM states
// and the glitch-filter length.
package logic_probe_pkg;

    typedef enum logic [1:0] {
        CLS_LOW  = 2'd0,
        CLS_HIGH = 2'd1,
        CLS_Z    = 2'd2
    } probe_class_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } probe_state_e;

    localparam int FILT_LEN = 3;

    // hi=1,lo=0 cannot happen with sane thresholds; it is reported as Z.
    function automatic probe_class_e classify(input logic hi, input logic lo);
        probe_class_e c;
        c = CLS_Z;
        if (hi && lo) begin
            c = CLS_HIGH;
        end else if (!hi && !lo) begin
            c = CLS_LOW;
        end
        return c;
    endfunction

endpackage

// File: rtl/probe_sync.sv
// Two-flop synchronizer for one asynchronous comparator output.
module probe_sync (
    input  logic clk,
    input  logic nreset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/logic_probe_counter.sv
// Logic probe: classifies the probe level every cycle and latches HIGH/LOW/Z/edge
// counts once per gate period. Optional glitch filter: PROBE_GLITCH_FILTER_EN.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | not measuring; accumulators held at zero
//   ST_MEASURE | accumulating; results latched every PERIOD cycles
module logic_probe_counter
    import logic_probe_pkg::*;
#(
    parameter int unsigned PERIOD       = 12000000,
    parameter int unsigned COUNTER_BITS = 24
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    comp_out_hi,
    input  logic                    comp_out_lo,
    input  logic                    enable,
    input  logic                    ack,
    output logic                    ready,
    output logic                    overrun,
    output logic [COUNTER_BITS-1:0] high_count,
    output logic [COUNTER_BITS-1:0] low_count,
    output logic [COUNTER_BITS-1:0] z_count,
    output logic [COUNTER_BITS-1:0] edge_count
);

    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] LAST_CYC = COUNTER_BITS'(PERIOD - 1);

    logic         hi_s;
    logic         lo_s;
    probe_class_e raw_cls;
    probe_class_e cls;

    probe_sync u_sync_hi (.clk(clk), .nreset(nreset), .d_i(comp_out_hi), .q_o(hi_s));
    probe_sync u_sync_lo (.clk(clk), .nreset(nreset), .d_i(comp_out_lo), .q_o(lo_s));

    assign raw_cls = classify(hi_s, lo_s);

`ifdef PROBE_GLITCH_FILTER_EN
    probe_class_e hist_q [FILT_LEN-1];
    probe_class_e acc_cls_q;
    logic         stable;

    // The current sample plus FILT_LEN-1 previous ones must agree.
    always_comb begin
        stable = 1'b1;
        for (int i = 0; i < FILT_LEN - 1; i++) begin
            if (hist_q[i] != raw_cls) stable = 1'b0;
        end
        cls = stable ? raw_cls : acc_cls_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < FILT_LEN - 1; i++) hist_q[i] <= CLS_LOW;
            acc_cls_q <= CLS_LOW;
        end else begin
            hist_q[0] <= raw_cls;
            for (int i = 1; i < FILT_LEN - 1; i++) hist_q[i] <= hist_q[i-1];
            acc_cls_q <= cls;
        end
    end
`else
    assign cls = raw_cls;
`endif

    probe_state_e            state_q;
    logic                    last_high_q;
    logic [COUNTER_BITS-1:0] per_cnt_q;
    logic [COUNTER_BITS-1:0] hi_acc_q, lo_acc_q, z_acc_q, edge_acc_q;
    logic [COUNTER_BITS-1:0] hi_acc_d, lo_acc_d, z_acc_d, edge_acc_d;
    logic                    is_edge;
    logic                    period_end;
    logic                    counting;

    function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] v,
                                                        input logic inc);
        return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    assign is_edge    = (cls == CLS_HIGH) && !last_high_q;
    assign hi_acc_d   = sat_inc(hi_acc_q, cls == CLS_HIGH);
    assign lo_acc_d   = sat_inc(lo_acc_q, cls == CLS_LOW);
    assign z_acc_d    = sat_inc(z_acc_q, cls == CLS_Z);
    assign edge_acc_d = sat_inc(edge_acc_q, is_edge);

    assign period_end = (state_q == ST_MEASURE) && enable && (per_cnt_q == LAST_CYC);
    assign counting   = (state_q == ST_MEASURE) && enable && !period_end;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            last_high_q <= 1'b0;
            per_cnt_q   <= '0;
            hi_acc_q    <= '0;
            lo_acc_q    <= '0;
            z_acc_q     <= '0;
            edge_acc_q  <= '0;
            high_count  <= '0;
            low_count   <= '0;
            z_count     <= '0;
            edge_count  <= '0;
            ready       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (cls == CLS_HIGH) begin
                last_high_q <= 1'b1;
            end else if (cls == CLS_LOW) begin
                last_high_q <= 1'b0;
            end

            // Leaving MEASURE, entering it, idling and a period end all restart from zero.
            if (counting) begin
                per_cnt_q  <= per_cnt_q + 1'b1;
                hi_acc_q   <= hi_acc_d;
                lo_acc_q   <= lo_acc_d;
                z_acc_q    <= z_acc_d;
                edge_acc_q <= edge_acc_d;
            end else begin
                per_cnt_q  <= '0;
                hi_acc_q   <= '0;
                lo_acc_q   <= '0;
                z_acc_q    <= '0;
                edge_acc_q <= '0;
            end

            if (period_end) begin
                high_count <= hi_acc_d;
                low_count  <= lo_acc_d;
                z_count    <= z_acc_d;
                edge_count <= edge_acc_d;
                ready      <= 1'b1;
                overrun    <= ready & ~ack;
            end else if (ack) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end

            case (state_q)
                ST_IDLE:    if (enable)  state_q <= ST_MEASURE;
                ST_MEASURE: if (!enable) state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_probe_counter.sv
// Bench for logic_probe_counter (PERIOD=100, COUNTER_BITS=8): scenario table,
// hand-written reset/glitch sequences and random traffic against a reference model.
module tb_logic_probe_counter;

    localparam int PERIOD = 100;
    localparam int CB     = 8;
    localparam int CMAX   = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          hi = 1'b0, lo = 1'b0, en = 1'b0, ack = 1'b0;
    logic          ready, overrun;
    logic [CB-1:0] high_count, low_count, z_count, edge_count;

    always #5 clk = ~clk;

    logic_probe_counter #(.PERIOD(PERIOD), .COUNTER_BITS(CB)) dut (
        .clk(clk), .nreset(nreset), .comp_out_hi(hi), .comp_out_lo(lo),
        .enable(en), .ack(ack), .ready(ready), .overrun(overrun),
        .high_count(high_count), .low_count(low_count),
        .z_count(z_count), .edge_count(edge_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model. Classes: 0=LOW 1=HIGH 2=Z.
    int m_in[$];
    int m_fh[$];
    int m_acc;
    bit m_last_high;
    bit m_meas;
    int m_phase;
    int m_cnt[3];
    int m_edges;
    int m_out[4];
    bit m_rdy, m_ov;

    function automatic int cls_of(bit h, bit l);
        if (h && l) return 1;
        if (!h && !l) return 0;
        return 2;
    endfunction

    function automatic void clear_acc();
        m_phase = 0;
        m_edges = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endfunction

    function automatic void model_reset();
        m_in = '{0, 0};
        m_fh = '{0, 0};
        m_acc = 0;
        m_last_high = 0;
        m_meas = 0;
        clear_acc();
        for (int i = 0; i < 4; i++) m_out[i] = 0;
        m_rdy = 0;
        m_ov = 0;
    endfunction

    function automatic int sat(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic void model_step(bit h, bit l, bit e, bit a);
        int c;
        bit new_edge;
        bit rdy_prev;
        m_in.push_back(cls_of(h, l));
        c = m_in[0];
        void'(m_in.pop_front());
`ifdef PROBE_GLITCH_FILTER_EN
        m_fh.push_back(c);
        if (m_fh[0] == m_fh[1] && m_fh[1] == m_fh[2]) m_acc = c;
        void'(m_fh.pop_front());
        c = m_acc;
`endif
        new_edge = (c == 1) && !m_last_high;
        if (c == 1) m_last_high = 1;
        else if (c == 0) m_last_high = 0;
        rdy_prev = m_rdy;
        if (a) begin
            m_rdy = 0;
            m_ov = 0;
        end
        if (!m_meas) begin
            if (e) begin
                m_meas = 1;
                clear_acc();
            end
        end else if (!e) begin
            m_meas = 0;
            clear_acc();
        end else begin
            m_cnt[c] = sat(m_cnt[c]);
            if (new_edge) m_edges = sat(m_edges);
            m_phase++;
            if (m_phase == PERIOD) begin
                m_out[0] = m_cnt[1];
                m_out[1] = m_cnt[0];
                m_out[2] = m_cnt[2];
                m_out[3] = m_edges;
                m_ov = rdy_prev && !a;
                m_rdy = 1;
                clear_acc();
            end
        end
    endfunction

    task automatic compare(string name, int eh, int el, int ez, int ee, bit er, bit eo);
        n_vec++;
        if (high_count !== CB'(eh) || low_count !== CB'(el) || z_count !== CB'(ez) ||
            edge_count !== CB'(ee) || ready !== er || overrun !== eo) begin
            n_bad++;
            $display("FAIL %s t=%0t: got hi=%0d lo=%0d z=%0d edge=%0d ready=%b overrun=%b, expected hi=%0d lo=%0d z=%0d edge=%0d ready=%b overrun=%b",
                     name, $time, high_count, low_count, z_count, edge_count, ready, overrun,
                     eh, el, ez, ee, er, eo);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!nreset) model_reset();
        else model_step(hi, lo, en, ack);
        @(negedge clk);
        compare("model", m_out[0], m_out[1], m_out[2], m_out[3], m_rdy, m_ov);
    endtask

    typedef struct {
        bit hi, lo, en, ack;
        int n;
        bit chk;
        int eh, el, ez, ee;
        bit er, eo;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit h, bit l, bit e, bit a, int n, bit chk,
                                int eh, int el, int ez, int ee, bit er, bit eo);
        vec_t v;
        v.hi = h; v.lo = l; v.en = e; v.ack = a; v.n = n; v.chk = chk;
        v.eh = eh; v.el = el; v.ez = ez; v.ee = ee; v.er = er; v.eo = eo;
        tbl.push_back(v);
    endfunction

    initial begin
        // Idle, then static HIGH for a full period.
        add(0, 0, 0, 0, 3,   1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 6,   1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 101, 1, 100, 0, 0, 0, 1, 0);
        // Square wave 10 LOW / 10 HIGH; ack on the first cycle.
        add(0, 0, 1, 1, 1,   1, 100, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 9,   0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++)
            add(k % 2 == 0, k % 2 == 0, 1, 0, 10, k == 8, 50, 50, 0, 5, 1, 0);
        // LOW -> Z -> HIGH (one edge), HIGH -> invalid(Z) -> HIGH (none); no ack.
        add(0, 0, 1, 0, 20,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 5,   1, 50, 50, 0, 5, 1, 0);
        add(1, 1, 1, 0, 20,  0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 5,   0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 50,  1, 70, 20, 10, 1, 1, 1);
        // Ack collides with the period end.
        add(1, 1, 1, 0, 99,  1, 70, 20, 10, 1, 1, 1);
        add(1, 1, 1, 1, 1,   1, 100, 0, 0, 0, 1, 0);
        // Disable mid-period, then a fresh full period.
        add(0, 0, 1, 0, 50,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 10,  1, 100, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 101, 1, 0, 100, 0, 0, 1, 1);

        model_reset();
        repeat (3) cyc();
        compare("reset_hold", 0, 0, 0, 0, 0, 0);
        nreset = 1'b1;

        foreach (tbl[i]) begin
            hi = tbl[i].hi; lo = tbl[i].lo; en = tbl[i].en; ack = tbl[i].ack;
            for (int c = 0; c < tbl[i].n; c++) begin
                cyc();
                ack = 1'b0;
            end
            if (tbl[i].chk)
                compare($sformatf("table[%0d]", i), tbl[i].eh, tbl[i].el, tbl[i].ez,
                        tbl[i].ee, tbl[i].er, tbl[i].eo);
        end

        // Reset 30 cycles into a period, stay idle without enable, then measure.
        hi = 0; lo = 0; en = 1;
        repeat (30) cyc();
        nreset = 1'b0;
        repeat (2) cyc();
        compare("reset_mid", 0, 0, 0, 0, 0, 0);
        nreset = 1'b1;
        en = 0;
        repeat (20) cyc();
        compare("idle_after_reset", 0, 0, 0, 0, 0, 0);
        en = 1;
        repeat (101) cyc();
        compare("first_after_reset", 0, 100, 0, 0, 1, 0);

        // 2-cycle HIGH glitches on LOW.
        for (int g = 0; g < 10; g++) begin
            hi = 0; lo = 0; ack = (g == 0);
            cyc();
            ack = 0;
            repeat (7) cyc();
            hi = 1; lo = 1;
            repeat (2) cyc();
        end
`ifdef PROBE_GLITCH_FILTER_EN
        compare("glitch", 0, 100, 0, 0, 1, 0);
`else
        compare("glitch", 18, 82, 0, 9, 1, 0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                hi = $urandom_range(0, 1);
                lo = $urandom_range(0, 1);
            end
            ack = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) en = ~en;
            else if (!en && $urandom_range(0, 4) == 0) en = 1;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
